// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Purpose  : Fetch PC and 32-bit instruction-word fetch for the NanoQuarter
//            core, feeding the prefetch buffer fill interface.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            buf_space,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_rd,
    output logic [PC_W-2:0] imem_addr,
    input  logic [31:0]     imem_data,
    input  logic            imem_valid,
    output logic [31:0]     exInst,
    output logic            write,
    output logic            skip_first,
    output logic [PC_W-1:0] fetch_pc
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [PC_W-2:0] c_word_one = {{(PC_W-2){1'b0}}, 1'b1};

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic              r_skip_pend;
    logic [31:0]       r_held;
    logic [31:0]       r_ex_inst;
    logic              r_write;
    logic              r_skip_first;
    logic [PC_W-1:0]   r_fetch_pc;

    state_t            w_state_nx;
    logic [PC_W-1:0]   w_pc_nx;
    logic              w_skip_nx;
    logic              w_space;
    logic              w_deliver;
    logic [31:0]       w_deliver_data;
    logic              w_held_load;
    logic [PC_W-2:0]   w_word_inc;

    assign w_space    = !stall && buf_space;
    assign w_word_inc = r_pc[PC_W-1:1] + c_word_one;

    // Gated by rst so no request escapes while the core is held in reset.
    assign imem_rd    = rst && (r_state == S_REQ) && w_space && !redirect;
    assign imem_addr  = r_pc[PC_W-1:1];

    assign exInst     = r_ex_inst;
    assign write      = r_write;
    assign skip_first = r_skip_first;
    assign fetch_pc   = r_fetch_pc;

    always_comb begin
        w_state_nx     = r_state;
        w_pc_nx        = r_pc;
        w_skip_nx      = r_skip_pend;
        w_deliver      = 1'b0;
        w_deliver_data = r_held;
        w_held_load    = 1'b0;

        case (r_state)
            S_REQ: begin
                if (!redirect && w_space) begin
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                // A redirect racing the response drops it; otherwise drain the stale one.
                if (redirect) begin
                    w_state_nx = imem_valid ? S_REQ : S_DRAIN;
                end else if (imem_valid) begin
                    if (w_space) begin
                        w_deliver      = 1'b1;
                        w_deliver_data = imem_data;
                        w_state_nx     = S_REQ;
                    end else begin
                        w_held_load = 1'b1;
                        w_state_nx  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_state_nx = S_REQ;
                end else if (w_space) begin
                    w_deliver  = 1'b1;
                    w_state_nx = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_valid) begin
                    w_state_nx = S_REQ;
                end
            end
            default: begin
                w_state_nx = S_REQ;
            end
        endcase

        if (w_deliver) begin
            w_pc_nx   = {w_word_inc, 1'b0};
            w_skip_nx = 1'b0;
        end
        if (redirect) begin
            w_pc_nx   = redirect_pc;
            w_skip_nx = redirect_pc[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_skip_pend  <= 1'b0;
            r_held       <= '0;
            r_ex_inst    <= '0;
            r_write      <= 1'b0;
            r_skip_first <= 1'b0;
            r_fetch_pc   <= RESET_PC;
        end else begin
            r_state     <= w_state_nx;
            r_pc        <= w_pc_nx;
            r_skip_pend <= w_skip_nx;
            r_write     <= w_deliver;
            if (w_held_load) begin
                r_held <= imem_data;
            end
            if (w_deliver) begin
                r_ex_inst    <= w_deliver_data;
                r_skip_first <= r_skip_pend;
                r_fetch_pc   <= {r_pc[PC_W-1:1], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_unit
// Purpose  : Cycle-by-cycle directed vector bench for inst_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam int PC_W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            buf_space;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            imem_rd;
    logic [PC_W-2:0] imem_addr;
    logic [31:0]     imem_data;
    logic            imem_valid;
    logic [31:0]     exInst;
    logic            write;
    logic            skip_first;
    logic [PC_W-1:0] fetch_pc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .PC_W     (PC_W),
        .RESET_PC (16'h0000)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .buf_space   (buf_space),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_valid  (imem_valid),
        .exInst      (exInst),
        .write       (write),
        .skip_first  (skip_first),
        .fetch_pc    (fetch_pc)
    );

    // One record per clock cycle: inputs for the cycle, then the outputs
    // expected in that cycle (registered ones reflect the previous edge).
    typedef struct {
        logic        stall;
        logic        bs;
        logic        rdr;
        logic [15:0] rpc;
        logic        vld;
        logic [31:0] data;
        logic        e_rd;
        logic [14:0] e_addr;
        logic        e_wr;
        logic [31:0] e_inst;
        logic        e_skip;
        logic [15:0] e_fpc;
    } vec_t;

    vec_t tbl_main[$];
    vec_t tbl_rst[$];

    function automatic vec_t mk(logic st, logic bs, logic rdr, logic [15:0] rpc,
                                logic vld, logic [31:0] data, logic e_rd,
                                logic [14:0] e_addr, logic e_wr, logic [31:0] e_inst,
                                logic e_skip, logic [15:0] e_fpc);
        vec_t v;
        v.stall = st;   v.bs = bs;       v.rdr = rdr;     v.rpc = rpc;
        v.vld = vld;    v.data = data;   v.e_rd = e_rd;   v.e_addr = e_addr;
        v.e_wr = e_wr;  v.e_inst = e_inst; v.e_skip = e_skip; v.e_fpc = e_fpc;
        return v;
    endfunction

    task automatic chk(input string name, input string tag, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s[%0d]: got %h expected %h", name, tag, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int idx);
        stall       = v.stall;
        buf_space   = v.bs;
        redirect    = v.rdr;
        redirect_pc = v.rpc;
        imem_valid  = v.vld;
        imem_data   = v.data;
        #1;
        chk("imem_rd",   tag, idx, {31'd0, imem_rd},   {31'd0, v.e_rd});
        chk("imem_addr", tag, idx, {17'd0, imem_addr}, {17'd0, v.e_addr});
        chk("write",     tag, idx, {31'd0, write},     {31'd0, v.e_wr});
        if (v.e_wr) begin
            chk("exInst",     tag, idx, exInst,               v.e_inst);
            chk("skip_first", tag, idx, {31'd0, skip_first},  {31'd0, v.e_skip});
            chk("fetch_pc",   tag, idx, {16'd0, fetch_pc},    {16'd0, v.e_fpc});
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk("imem_rd",    tag, 0, {31'd0, imem_rd},    32'd0);
        chk("imem_addr",  tag, 0, {17'd0, imem_addr},  32'd0);
        chk("write",      tag, 0, {31'd0, write},      32'd0);
        chk("exInst",     tag, 0, exInst,              32'd0);
        chk("skip_first", tag, 0, {31'd0, skip_first}, 32'd0);
        chk("fetch_pc",   tag, 0, {16'd0, fetch_pc},   32'd0);
    endtask

    initial begin
        //                 st bs rd rpc       vld data            rd addr      wr inst            sk fpc
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 0, 32'h0,          1, 15'h0000, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 1, 32'h4000_4020,  0, 15'h0000, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 0, 32'h0,          1, 15'h0001, 1, 32'h4000_4020,  0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 1, 32'h0040_0040,  0, 15'h0001, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 0, 0, 16'h0000, 0, 32'h0,          0, 15'h0002, 1, 32'h0040_0040,  0, 16'h0002));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 0, 32'h0,          1, 15'h0002, 0, 32'h0,          0, 16'h0000));
        // Response arrives with no buffer space -> HOLD
        tbl_main.push_back(mk(0, 0, 0, 16'h0000, 1, 32'h2EF8_3A68,  0, 15'h0002, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 0, 0, 16'h0000, 0, 32'h0,          0, 15'h0002, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(1, 1, 0, 16'h0000, 0, 32'h0,          0, 15'h0002, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 0, 32'h0,          0, 15'h0002, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 0, 32'h0,          1, 15'h0003, 1, 32'h2EF8_3A68,  0, 16'h0004));
        // Redirect to odd target while WAIT, stale data arrives in DRAIN
        tbl_main.push_back(mk(0, 1, 1, 16'h0007, 0, 32'h0,          0, 15'h0003, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 1, 32'hDEAD_BEEF,  0, 15'h0003, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 0, 32'h0,          1, 15'h0003, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 1, 32'h1111_2222,  0, 15'h0003, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 0, 32'h0,          1, 15'h0004, 1, 32'h1111_2222,  1, 16'h0006));
        // Redirect coincident with imem_valid: data dropped
        tbl_main.push_back(mk(0, 1, 1, 16'h0010, 1, 32'h3333_4444,  0, 15'h0004, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 0, 32'h0,          1, 15'h0008, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 1, 32'h5555_6666,  0, 15'h0008, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 0, 32'h0,          1, 15'h0009, 1, 32'h5555_6666,  0, 16'h0010));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 1, 32'h6666_7777,  0, 15'h0009, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 0, 0, 16'h0000, 0, 32'h0,          0, 15'h000A, 1, 32'h6666_7777,  0, 16'h0012));
        // Redirect from REQ to the top of the address space, then wrap
        tbl_main.push_back(mk(0, 1, 1, 16'hFFFE, 0, 32'h0,          0, 15'h000A, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 0, 32'h0,          1, 15'h7FFF, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 1, 32'h7777_8888,  0, 15'h7FFF, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 0, 32'h0,          1, 15'h0000, 1, 32'h7777_8888,  0, 16'hFFFE));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 1, 32'h9999_AAAA,  0, 15'h0000, 0, 32'h0,          0, 16'h0000));
        tbl_main.push_back(mk(0, 1, 0, 16'h0000, 0, 32'h0,          1, 15'h0001, 1, 32'h9999_AAAA,  0, 16'h0000));

        // After a mid-WAIT reset: the orphaned response lands in REQ and is ignored
        tbl_rst.push_back(mk(0, 1, 0, 16'h0000, 1, 32'hBBBB_CCCC,   1, 15'h0000, 0, 32'h0,          0, 16'h0000));
        tbl_rst.push_back(mk(0, 1, 0, 16'h0000, 0, 32'h0,          0, 15'h0000, 0, 32'h0,          0, 16'h0000));
        tbl_rst.push_back(mk(0, 1, 0, 16'h0000, 1, 32'hDDDD_0000,   0, 15'h0000, 0, 32'h0,          0, 16'h0000));
        tbl_rst.push_back(mk(0, 1, 0, 16'h0000, 0, 32'h0,          1, 15'h0001, 1, 32'hDDDD_0000,  0, 16'h0000));

        rst         = 1'b1;
        stall       = 1'b0;
        buf_space   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_valid  = 1'b0;
        imem_data   = '0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < tbl_main.size(); i++) begin
            run_vec(tbl_main[i], "main", i);
        end

        // Reset asserted while a request is outstanding
        rst        = 1'b0;
        imem_valid = 1'b0;
        buf_space  = 1'b1;
        stall      = 1'b0;
        redirect   = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < tbl_rst.size(); i++) begin
            run_vec(tbl_rst[i], "postrst", i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
